// File: rtl/sprite_draw_scheduler.sv
// Per-frame scheduler that time-shares one VGA pixel-write port among N sprite slots.
// Optional macro SCHED_SKIP_STATIC_EN skips erase/redraw of slots that have not moved.
module sprite_draw_scheduler #(
    parameter int unsigned N_SLOTS   = 10,
    parameter int unsigned SPR_W     = 4,
    parameter int unsigned SPR_H     = 4,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter logic [2:0]  BG_COLOUR = 3'b000,
    localparam int unsigned SLOT_W   = $clog2(N_SLOTS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    output logic [SLOT_W-1:0] slot_sel,
    input  logic [7:0]        slot_x,
    input  logic [6:0]        slot_y,
    input  logic              slot_vis,
    input  logic [2:0]        slot_colour,
    output logic [7:0]        x_out,
    output logic [6:0]        y_out,
    output logic [2:0]        colour_out,
    output logic              plot,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(SPR_H - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);
    localparam logic [8:0]        SCR_W9    = 9'(SCREEN_W);
    localparam logic [7:0]        SCR_H8    = 8'(SCREEN_H);

    typedef enum logic [2:0] {StIdle, StLoad, StErase, StDraw, StNext, StDone} state_e;

    state_e             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [7:0]         cap_x_q, cap_x_d;
    logic [6:0]         cap_y_q, cap_y_d;
    logic               cap_vis_q, cap_vis_d;
    logic [2:0]         cap_col_q, cap_col_d;

    logic [7:0]         prev_x_q [N_SLOTS];
    logic [6:0]         prev_y_q [N_SLOTS];
    logic [N_SLOTS-1:0] prev_valid_q;

    logic               last_pix;
    logic               sweep_d;
    logic               erase_d;
    logic [7:0]         base_x;
    logic [6:0]         base_y;
    logic [8:0]         px9;
    logic [7:0]         py8;

    assign slot_sel   = slot_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        col_d     = col_q;
        row_d     = row_q;
        cap_x_d   = cap_x_q;
        cap_y_d   = cap_y_q;
        cap_vis_d = cap_vis_q;
        cap_col_d = cap_col_q;
        last_pix  = (col_q == COL_MAX) && (row_q == ROW_MAX);

        unique case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    slot_d  = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cap_x_d   = slot_x;
                cap_y_d   = slot_y;
                cap_vis_d = slot_vis;
                cap_col_d = slot_colour;
                col_d     = '0;
                row_d     = '0;
                if (prev_valid_q[slot_q]) begin
`ifdef SCHED_SKIP_STATIC_EN
                    if (slot_vis && (slot_x == prev_x_q[slot_q]) && (slot_y == prev_y_q[slot_q]))
                        state_d = StNext;
                    else
                        state_d = StErase;
`else
                    state_d = StErase;
`endif
                end else if (slot_vis) begin
                    state_d = StDraw;
                end else begin
                    state_d = StNext;
                end
            end
            StErase, StDraw: begin
                if (last_pix) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = ((state_q == StErase) && cap_vis_q) ? StDraw : StNext;
                end else if (col_q == COL_MAX) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StNext: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = StDone;
                end else begin
                    slot_d  = slot_q + 1'b1;
                    state_d = StLoad;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pixel registers are loaded from next-state values so the first pixel appears
    // in the cycle the sweep state is entered.
    always_comb begin
        erase_d = (state_d == StErase);
        sweep_d = erase_d || (state_d == StDraw);
        base_x  = erase_d ? prev_x_q[slot_q] : cap_x_d;
        base_y  = erase_d ? prev_y_q[slot_q] : cap_y_d;
        px9     = {1'b0, base_x} + 9'(col_d);
        py8     = {1'b0, base_y} + 8'(row_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            cap_x_q      <= '0;
            cap_y_q      <= '0;
            cap_vis_q    <= 1'b0;
            cap_col_q    <= '0;
            x_out        <= '0;
            y_out        <= '0;
            colour_out   <= '0;
            plot         <= 1'b0;
            overrun      <= 1'b0;
            prev_valid_q <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                prev_x_q[i] <= '0;
                prev_y_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cap_x_q   <= cap_x_d;
            cap_y_q   <= cap_y_d;
            cap_vis_q <= cap_vis_d;
            cap_col_q <= cap_col_d;
            if (sweep_d) begin
                x_out      <= px9[7:0];
                y_out      <= py8[6:0];
                colour_out <= erase_d ? BG_COLOUR : cap_col_d;
            end
            plot    <= sweep_d && (px9 < SCR_W9) && (py8 < SCR_H8);
            overrun <= frame_tick && (state_q != StIdle);
            if (state_q == StNext) begin
                prev_x_q[slot_q]     <= cap_x_q;
                prev_y_q[slot_q]     <= cap_y_q;
                prev_valid_q[slot_q] <= cap_vis_q;
            end
        end
    end

endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
Per-frame sequencer that shares the single VGA pixel-write port (x, y, colour, plot) among N sprite slots, e.g. the enemy planes. On each frame_tick it walks slots 0..N_SLOTS-1. For each slot it erases the rectangle at the slot's previous position, then draws it at its current position, one pixel per clock. It sits between the object controllers (which own the coordinates and visibility) and the VGA adapter.

Parameters:
N_SLOTS, 10, number of sprite slots scanned per frame (2..16); SLOT_W = clog2(N_SLOTS) is derived.
SPR_W, 4, sprite width in pixels (1..8).
SPR_H, 4, sprite height in pixels (1..8).
SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped.
SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped.
BG_COLOUR, 3'b000, colour used for erase.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse that starts a frame pass
slot_sel  out  SLOT_W  index of the slot being fetched
slot_x  in  8  top-left x of the selected slot (combinational from owner)
slot_y  in  7  top-left y of the selected slot
slot_vis  in  1  selected slot is visible
slot_colour  in  3  draw colour of the selected slot
x_out  out  8  pixel x to VGA adapter
y_out  out  7  pixel y to VGA adapter
colour_out  out  3  pixel colour
plot  out  1  write strobe to VGA adapter
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse when a pass completes
overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset (sync, active-low): state=IDLE; slot_sel=0; x_out=0; y_out=0; colour_out=0; plot=0; busy=0; frame_done=0; overrun=0; prev_valid[all]=0; prev_x/prev_y store=0.
- States: IDLE, LOAD, ERASE, DRAW, NEXT, DONE.
- IDLE: on frame_tick, set slot=0 and go to LOAD.
- LOAD (1 cycle): capture slot_x, slot_y, slot_vis, slot_colour for slot_sel.
  - If prev_valid[slot]: go to ERASE.
  - Else if vis: go to DRAW.
  - Else: go to NEXT.
- ERASE: sweep SPR_W*SPR_H cycles at prev_x/prev_y with colour BG_COLOUR. Then go to DRAW if vis, else NEXT.
- DRAW: sweep SPR_W*SPR_H cycles at captured x/y with captured colour, then go to NEXT.
- Sweep order: row-major, column fastest. x_out = base_x + col (9-bit compare before truncation); y_out = base_y + row (8-bit compare).
- Clipping: a pixel with x >= SCREEN_W or y >= SCREEN_H still consumes its cycle, but plot=0 for that pixel.
- plot is high only in ERASE/DRAW cycles with an unclipped pixel. x_out, y_out, colour_out and plot are registered, with no combinational path from the slot_* inputs.
- NEXT (1 cycle):
  - prev_x/prev_y[slot] <= captured x/y; prev_valid[slot] <= vis.
  - If slot == N_SLOTS-1, go to DONE; else slot+1 and go to LOAD.
- DONE: frame_done=1 for exactly one cycle, then go to IDLE.
- Cycles per slot = 2 + SPR_W*SPR_H*(prev_valid + vis).
- frame_tick while busy (any state including DONE): the tick is dropped, the current pass continues, and overrun pulses for 1 cycle.
- Reset mid-pass: the pass is aborted on the next edge and plot=0. prev_valid is cleared, so stale pixels stay on screen; clearing the screen is the top level's job.
- slot_x/slot_y changes after LOAD do not affect the current slot's sweep.

Optional Feature:
SCHED_SKIP_STATIC_EN.
- Defined: in LOAD, if prev_valid[slot]=1, vis=1, and x/y equal prev_x/prev_y, the slot goes straight to NEXT with zero plots. The slot's colour is not re-checked.
- Not defined: every slot is always erased and redrawn per the rules above.

Test Plan:
1. N_SLOTS=2, SPR 4x4, after reset. Slot0 vis at (10,20) colour 111; slot1 invisible. frame_tick at T -> 16 plot pulses with x 10..13, y 20..23, colour 111 during T+2..T+17; frame_done at T+21 only; busy high T+1..T+21.
2. Second frame after test 1, with slot0 moved to (10,21) -> 16 plots colour 000 at y 20..23, then 16 plots colour 111 at y 21..24; prev updated.
3. Slot0 vis at (158,118) -> 16 sweep cycles, with plot=1 only at (158,118), (159,118), (158,119), (159,119).
4. frame_tick again 5 cycles into a pass -> overrun=1 for one cycle; exactly one frame_done; no restart.
5. reset_n low during DRAW -> next cycle plot=0, busy=0. The following frame issues no erase plots for any slot.
6. With SCHED_SKIP_STATIC_EN, two identical frames -> second frame has zero plot pulses and frame_done at T+2*N_SLOTS+1. Without the macro, it has 32 plots per visible slot.
